// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the data memory controller.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    misalign = misaligned(size, lane);
    be       = 4'b0000;
    wword    = wdata;
    rdata    = '0;
    bsel     = rword[{lane, 3'b000} +: 8];
    hsel     = lane[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        rdata = {{24{~uns & bsel[7]}}, bsel};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{~uns & hsel[15]}}, hsel};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data RAM with sub-word access, error detection,
// valid/ready handshake and an optional post-reset clear sequencer.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          range_err, misalign, err, accept, wr;
  logic [3:0]    be;
  logic [31:0]   rword, wword, ld_data;

  assign idx       = req_addr[AW+1:2];
  assign lane      = req_addr[1:0];
  assign range_err = |req_addr[31:AW+2];
  assign rword     = mem[idx];

  mem_lane_align u_align (
    .size     (req_size),
    .lane     (lane),
    .uns      (req_unsigned),
    .wdata    (req_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_data),
    .misalign (misalign)
  );

  assign err    = (req_size == SZ_RSVD) || misalign || range_err;
  assign accept = req_valid && req_ready;
  assign wr     = accept && req_we && !err;

  // req_ready is held low while rst is high so nothing slips in on the release edge.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      ST_INIT: begin
        busy  = 1'b1;
        cnt_d = cnt + 1'b1;
        if (cnt == LAST) state_d = ST_READY;
      end
      ST_READY: req_ready = !rst && (!resp_valid || resp_ready);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        resp_valid <= 1'b1;
        resp_rdata <= (err || req_we) ? 32'h0 : ld_data;
        resp_err   <= err;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Array has no reset; contents only change via clear or enabled byte writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised successor to the core's data memory. Provides a word-organised RAM with arbitrary-offset byte/half/word access, sign/zero-extended loads, misalignment and range errors, and a valid/ready request/response handshake with 1-cycle registered read latency. An optional post-reset clear sequencer zeroes the array. Sits between the MEM stage and on-chip data storage.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two, >= 2)
AW, $clog2(DEPTH), word-index width (derived, not overridden)
CLEAR_ON_RESET, 1, 1 = zero whole array after reset before accepting requests

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  32  load data, extended; 0 for stores and errors
resp_err  out  1  request faulted (misaligned, out of range, reserved size)
busy  out  1  clear sequence in progress

Behaviour:
- Reset (async assert): state <= INIT if CLEAR_ON_RESET else READY; resp_valid=0, resp_rdata=0, resp_err=0, clear counter=0, busy=CLEAR_ON_RESET. Array contents untouched by reset itself.
- INIT: one word per cycle, mem[cnt] <= 0, cnt++; after writing index DEPTH-1 -> READY (busy=0 next cycle). Clear takes exactly DEPTH cycles. req_ready=0 throughout.
- Reset mid-clear restarts clear at index 0. Reset mid-transaction drops the pending response; a store accepted at the edge before reset is committed.
- READY: req_ready = !resp_valid || resp_ready (one-entry response slot, full throughput when resp_ready held high).
- Accept at edge N -> resp_valid=1 at N+1 with rdata/err. Store commits to array at edge N. Load reads array at edge N, so store then load to same address back-to-back returns new data.
- resp_valid stays high and resp_rdata/resp_err stay stable until resp_ready; a new accept in the same cycle as consumption replaces the slot without a bubble. Neither valid nor ready is asserted combinationally from the other side's valid.
- Index = addr[AW+1:2]; lane = addr[1:0].
- Errors (resp_err=1, rdata=0, no array write): size 11; half with addr[0]=1; word with addr[1:0]!=0; any addr bit [31:AW+2] set.
- Store byte: byte enable 1<<lane, data wdata[7:0] replicated to all lanes. Half: enables 0011 (addr[1]=0) or 1100, data wdata[15:0] replicated. Word: 1111. Unenabled bytes unchanged.
- Load byte: byte at lane, extended to 32 per req_unsigned. Half: half selected by addr[1], extended. Word: whole word, req_unsigned ignored.
- Simultaneous reset deassertion and req_valid: no accept that cycle (req_ready low during reset).

Decomposition:
- Package data_mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, state encodings ST_INIT/ST_READY, function for misalignment check.
- Sub-module mem_lane_align (combinational): inputs size, lane, unsigned, wdata, raw read word; outputs 4-bit byte enable, lane-replicated store word, extended load data, misalign flag. Top holds FSM, clear counter, array and response register.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: release rst -> busy=1 and req_ready=0 for exactly 16 cycles, then any word load returns 0x00000000, err=0.
- Store word 0x80FF7F01 @0x8, then loads with resp_ready=1 back-to-back: LB @0x8 -> 0x00000001; LB @0xB -> 0xFFFFFF80; LBU @0xB -> 0x00000080; LH @0xA -> 0xFFFF80FF; LHU @0x8 -> 0x00007F01; one response per cycle.
- SB 0xAB @0x5 over word 0x11223344 @0x4 -> LW @0x4 = 0x1122AB44; SH 0xBEEF @0x6 -> LW = 0xBEEFAB44.
- LW @0x6, LH @0x3, size=11, LW @(DEPTH*4) -> each resp_err=1, rdata=0; previously stored word unchanged.
- Hold resp_ready=0 two cycles after a load: resp_valid/rdata stable, req_ready=0, second request stalls; raise resp_ready -> second request accepted same cycle, its response next cycle.
- Assert rst during clear at index 5 and during a pending load response -> resp_valid=0 immediately; clear restarts and runs full DEPTH cycles.
